// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: halts the CPU and copies XFER_LEN bytes from page {data,8'h00} to the OAM data port.
// Optional define OAM_DMA_CYCLE_CNT_EN adds o_DMA_CYCLES (halted cycles of the last completed DMA).
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [15:0] DEST_ADDR    = 16'h2004,
    parameter int          XFER_LEN     = 256
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic [15:0] i_CPU_ADDR,
    input  logic [7:0]  i_CPU_DATA,
    input  logic        i_CPU_R_WN,
    output logic        o_CPU_HALT,
    output logic [15:0] o_ADDR,
    output logic [7:0]  o_DATA,
    output logic        o_R_WN,
    input  logic [7:0]  i_DATA,
    output logic        o_BUSY
`ifdef OAM_DMA_CYCLE_CNT_EN
    ,
    output logic [15:0] o_DMA_CYCLES
`endif
);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
    state_t      state_q, state_d;
    logic        parity_q, parity_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        last;
`ifdef OAM_DMA_CYCLE_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cyc_q, cyc_d;
    assign o_DMA_CYCLES = cyc_q;
`endif
    // 9-bit compare so XFER_LEN=256 terminates at index 8'hFF
    assign last = ({1'b0, idx_q} == 9'(XFER_LEN - 1));
    always_comb begin
        state_d    = state_q;
        parity_d   = ~parity_q;
        page_d     = page_q;
        idx_d      = idx_q;
        data_d     = data_q;
        o_CPU_HALT = (state_q != IDLE);
        o_BUSY     = (state_q != IDLE);
        o_ADDR     = i_CPU_ADDR;
        o_DATA     = i_CPU_DATA;
        o_R_WN     = i_CPU_R_WN;
`ifdef OAM_DMA_CYCLE_CNT_EN
        cnt_d      = (state_q == IDLE) ? 16'd0 : cnt_q + 16'd1;
        cyc_d      = (state_q == WRITE && last) ? cnt_q + 16'd1 : cyc_q;
`endif
        case (state_q)
            IDLE: begin
                if (!i_CPU_R_WN && i_CPU_ADDR == DMA_REG_ADDR) begin
                    page_d  = i_CPU_DATA;
                    idx_d   = 8'd0;
                    state_d = HALT;
                end
            end
            HALT, ALIGN: begin
                o_R_WN  = 1'b1;
                o_DATA  = 8'h00;
                // reads must start on an even cycle: parity_q=1 now means 0 next cycle
                state_d = (state_q == ALIGN || parity_q) ? READ : ALIGN;
            end
            READ: begin
                o_ADDR  = {page_q, idx_q};
                o_DATA  = 8'h00;
                o_R_WN  = 1'b1;
                data_d  = i_DATA;
                state_d = WRITE;
            end
            WRITE: begin
                o_ADDR  = DEST_ADDR;
                o_DATA  = data_q;
                o_R_WN  = 1'b0;
                idx_d   = last ? idx_q : idx_q + 8'd1;
                state_d = last ? IDLE : READ;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q  <= IDLE;
            parity_q <= 1'b0;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            data_q   <= 8'h00;
`ifdef OAM_DMA_CYCLE_CNT_EN
            cnt_q    <= 16'd0;
            cyc_q    <= 16'd0;
`endif
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
`ifdef OAM_DMA_CYCLE_CNT_EN
            cnt_q    <= cnt_d;
            cyc_q    <= cyc_d;
`endif
        end
    end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: directed checks of passthrough, aligned/unaligned DMA, page $FF, abort and back-to-back.
module tb_oam_dma_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = 16'h8000;
    logic [7:0]  cpu_data = 8'h00;
    logic        cpu_r_wn = 1'b1;
    logic        halt, r_wn, busy;
    logic [15:0] addr;
    logic [7:0]  data, rdata;
    logic        par = 1'b0;
    int          checks = 0;
    int          errors = 0;
`ifdef OAM_DMA_CYCLE_CNT_EN
    logic [15:0] dma_cycles;
`endif

    oam_dma_ctrl dut (
        .i_CLK(clk), .i_RST(rst), .i_CPU_ADDR(cpu_addr), .i_CPU_DATA(cpu_data),
        .i_CPU_R_WN(cpu_r_wn), .o_CPU_HALT(halt), .o_ADDR(addr), .o_DATA(data),
        .o_R_WN(r_wn), .i_DATA(rdata), .o_BUSY(busy)
`ifdef OAM_DMA_CYCLE_CNT_EN
        , .o_DMA_CYCLES(dma_cycles)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) par <= rst ? 1'b0 : ~par;

    function automatic logic [7:0] ram(input logic [15:0] a);
        if (a[15:8] == 8'h02) return a[7:0] ^ 8'hA5;
        if (a[15:8] == 8'hFF) return a[7:0] ^ 8'h3C;
        return a[7:0] + a[15:8];
    endfunction
    assign rdata = ram(addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_par(input logic p);
        @(posedge clk); #1;
        if (par !== p) begin @(posedge clk); #1; end
    endtask

    task automatic run_dma(input logic [7:0] page, input int abort_at);
        int hc = 0, wc = 0, bad = 0, w2004 = 0;
        logic [15:0] lastr = 16'h0000;
        bit zero_acc = 0;
        int exp_h = 513 + int'(par);
        cpu_addr = 16'h4014; cpu_data = page; cpu_r_wn = 1'b0;
        #1;
        check("trig_bus", {addr, r_wn, halt}, {16'h4014, 1'b0, 1'b0});
        @(posedge clk); #1;
        cpu_addr = 16'h8000; cpu_data = 8'h00; cpu_r_wn = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!halt) break;
            hc++;
            if (addr == 16'h0000) zero_acc = 1;
            if (!r_wn) begin
                if (addr !== 16'h2004 || data !== ram({page, 8'(wc)})) bad++;
                if (wc == abort_at) begin
                    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
                    break;
                end
                wc++;
            end else if (addr != 16'h8000) begin
                if (addr !== {page, 8'(wc)}) bad++;
                lastr = addr;
            end
        end
        if (abort_at >= 0) begin
            @(negedge clk);
            check("abort_idle", {halt, busy}, 2'b00);
            check("abort_pass", {addr, r_wn}, {16'h8000, 1'b1});
            check("abort_wc", wc, abort_at);
            check("abort_seq", bad, 0);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!r_wn && addr == 16'h2004) w2004++;
            end
            check("abort_nowr", w2004, 0);
`ifdef OAM_DMA_CYCLE_CNT_EN
            check("abort_cyc", dma_cycles, 0);
`endif
        end else begin
            check("halt_cycles", hc, exp_h);
            check("writes", wc, 256);
            check("seq", bad, 0);
            check("last_read", lastr, {page, 8'hFF});
            check("no_zero", zero_acc, 0);
            check("done_idle", {busy, addr, r_wn}, {1'b0, 16'h8000, 1'b1});
`ifdef OAM_DMA_CYCLE_CNT_EN
            check("dma_cycles", dma_cycles, exp_h);
`endif
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_halt", halt, 0);
        check("rst_busy", busy, 0);
        check("rst_pass", {addr, r_wn}, {16'h8000, 1'b1});
`ifdef OAM_DMA_CYCLE_CNT_EN
        check("rst_cyc", dma_cycles, 0);
`endif
        cpu_addr = 16'h0123; cpu_r_wn = 1'b1;
        #1;
        check("pt_read", {addr, r_wn, halt}, {16'h0123, 1'b1, 1'b0});
        cpu_addr = 16'h0200; cpu_data = 8'h5A; cpu_r_wn = 1'b0;
        #1;
        check("pt_write", {addr, data, r_wn, halt}, {16'h0200, 8'h5A, 1'b0, 1'b0});
        @(posedge clk); #1;
        cpu_addr = 16'h8000; cpu_data = 8'h00; cpu_r_wn = 1'b1;
        wait_par(1'b0); run_dma(8'h02, -1);
        wait_par(1'b1); run_dma(8'h02, -1);
        wait_par(1'b0); run_dma(8'hFF, -1);
        wait_par(1'b1); run_dma(8'h02, 99);
        wait_par(1'b0); run_dma(8'h03, -1);
        run_dma(8'h02, -1);
        run_dma(8'hFF, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Bus master arbiter between the cpu_6502 core and the NES sprite DMA engine on the CPU address/data bus.
- A CPU write to the DMA register halts the CPU and takes ownership of the bus.
- The block then copies XFER_LEN bytes from page {data,8'h00} to the PPU OAM data port.
- When idle it is transparent: the CPU bus passes straight through to the shared bus (RAM, PPU, APU).

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA.
- DEST_ADDR, 16'h2004, fixed write target for every transferred byte.
- XFER_LEN, 256, bytes per transfer; legal range 1..256.

Ports:
- i_CLK  input  1  CPU clock (1.79 MHz domain).
- i_RST  input  1  synchronous active-high reset.
- i_CPU_ADDR  input  16  CPU address.
- i_CPU_DATA  input  8  CPU write data.
- i_CPU_R_WN  input  1  CPU read=1 / write=0.
- o_CPU_HALT  output  1  high = CPU must hold its state this cycle (clock-enable gate).
- o_ADDR  output  16  shared bus address.
- o_DATA  output  8  shared bus write data.
- o_R_WN  output  1  shared bus read/write.
- i_DATA  input  8  shared bus read data; valid at end of the cycle in which o_ADDR is presented.
- o_BUSY  output  1  DMA in progress (any state other than IDLE).

Behaviour:
- Reset values (sync, i_RST=1 at a clock edge):
  - state=IDLE, o_CPU_HALT=0, o_BUSY=0, parity=0, byte index=0, latches=0.
  - Bus outputs follow the CPU passthrough.
  - Reset mid-transfer aborts immediately; the next cycle is IDLE passthrough with no partial write.
- parity bit: toggles every clock, cleared by reset.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - o_ADDR=i_CPU_ADDR, o_DATA=i_CPU_DATA, o_R_WN=i_CPU_R_WN.
  - If i_CPU_R_WN=0 and i_CPU_ADDR==DMA_REG_ADDR: latch page<=i_CPU_DATA, index<=0, go to HALT.
  - The triggering write still appears on the bus.
- HALT: one dummy cycle.
  - o_CPU_HALT=1, o_ADDR=i_CPU_ADDR, o_R_WN forced 1, o_DATA=0.
  - Next state is READ if parity (value in the next cycle) is 0, else ALIGN.
- ALIGN: one extra dummy cycle, same bus values as HALT; then READ.
- READ:
  - o_ADDR={page,index}, o_R_WN=1.
  - i_DATA captured into the data latch at the end of the cycle; then WRITE.
- WRITE:
  - o_ADDR=DEST_ADDR, o_DATA=latched byte, o_R_WN=0.
  - If index==XFER_LEN-1, go to IDLE; else index+1 and go to READ.
- o_CPU_HALT and o_BUSY are 1 in HALT, ALIGN, READ and WRITE; they drop in the first IDLE cycle.
- Total halted cycles = 1 + (ALIGN?1:0) + 2*XFER_LEN (513 or 514 for the default).
- Address arithmetic: index is 8-bit (9-bit comparison for XFER_LEN=256); {page,index} never crosses the page.
- Page $FF reads $FF00-$FFFF with no wrap into page 0.
- Writes to DMA_REG_ADDR while busy: impossible (CPU halted); inputs are ignored outside IDLE.
- Back-to-back: a new trigger in the first IDLE cycle after completion starts a new DMA normally.
- All outputs are combinational from state and registers; there is no bus-facing pipeline delay.

Optional Feature:
- Macro: OAM_DMA_CYCLE_CNT_EN.
- Defined:
  - Adds output o_DMA_CYCLES[15:0] holding the halted-cycle count of the last completed DMA (513 or 514 for the default).
  - Updated in the cycle state returns to IDLE.
  - Reset to 0; not updated on an aborted transfer.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Passthrough: CPU read $0123, then write 8'h5A to $0200 while idle -> o_ADDR/o_DATA/o_R_WN equal the CPU values in the same cycle; o_CPU_HALT=0.
- Even-aligned DMA:
  - Stimulus: RAM $0200-$02FF = index^8'hA5; CPU writes 8'h02 to $4014 so that HALT is followed by even parity.
  - Required response: no ALIGN; 256 writes to $2004 with data index^8'hA5 in order; o_CPU_HALT high for exactly 513 cycles.
- Odd-aligned DMA: same stimulus shifted by one cycle -> one ALIGN cycle; halt for exactly 514 cycles; identical data sequence.
- Page $FF: trigger with 8'hFF -> reads $FF00..$FFFF; last read address $FFFF; no access to $0000.
- Reset mid-transfer:
  - Stimulus: assert i_RST during the 100th WRITE.
  - Required response: next cycle o_CPU_HALT=0, o_BUSY=0, bus = CPU passthrough; no further $2004 writes.
  - A fresh trigger afterwards completes normally.
- Back-to-back: trigger again in the first IDLE cycle after completion -> second DMA runs fully; with OAM_DMA_CYCLE_CNT_EN, o_DMA_CYCLES reads 513 or 514 after each.
